// File: rtl/board_reader.sv
// Scans the board RAM (one-cycle read latency) into a packed board vector plus per-column
// piece counts; the committed outputs change only in the single cycle that ends a scan.
module board_reader #(
  parameter int CELLS  = 49,
  parameter int COLS   = 7,
  parameter int CELL_W = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic                    start,
  output logic [5:0]              ram_addr,
  input  logic [CELL_W-1:0]       ram_q,
  output logic [CELLS*CELL_W-1:0] board,
  output logic [COLS*3-1:0]       heights,
  output logic                    board_full,
  output logic                    busy,
  output logic                    done,
  output logic                    board_valid,
  output logic [1:0]              dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [5:0] LAST_ADDR = 6'(CELLS - 1);
  localparam logic [2:0] LAST_COL  = 3'(COLS - 1);
  localparam int BW = CELLS * CELL_W;
  localparam int HW = COLS * 3;

  logic [1:0]    state_q, state_d;
  logic [5:0]    addr_q, addr_d;
  logic [5:0]    addr_d1_q;
  logic          vld_d1_q;
  logic [2:0]    col_q, col_d;
  logic [BW-1:0] shadow_q, shadow_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] board_q, board_d;
  logic [HW-1:0] heights_q, heights_d;
  logic          full_q, full_d;
  logic          valid_q, valid_d;
  logic [BW-1:0] cap_board;
  logic [HW-1:0] cap_cnt;
  logic          cap_full;

  // start is a level request: it is taken at any edge where the block is not busy
  // (IDLE or DONE) and ignored otherwise; done is the one-cycle completion strobe.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    col_d     = col_q;
    board_d   = board_q;
    heights_d = heights_q;
    full_d    = full_q;
    valid_d   = valid_q;
    cap_board = shadow_q;
    cap_cnt   = cnt_q;
    cap_full  = 1'b1;

    // Merge the cell returning from the RAM this cycle (tagged by the delayed address).
    if (vld_d1_q) begin
      for (int a = 0; a < CELLS; a++) begin
        if (addr_d1_q == 6'(a)) cap_board[a*CELL_W +: CELL_W] = ram_q;
      end
      if (ram_q != '0) begin
        for (int c = 0; c < COLS; c++) begin
          if (col_q == 3'(c)) cap_cnt[c*3 +: 3] = cap_cnt[c*3 +: 3] + 3'd1;
        end
      end
      col_d = (col_q == LAST_COL) ? 3'd0 : col_q + 3'd1;
    end
    for (int c = 0; c < COLS; c++) begin
      if (cap_cnt[c*3 +: 3] != 3'd7) cap_full = 1'b0;
    end
    shadow_d = cap_board;
    cnt_d    = cap_cnt;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          state_d  = S_READ;
          addr_d   = 6'd0;
          col_d    = 3'd0;
          cnt_d    = '0;
          shadow_d = '0;
        end
      end
      S_READ: begin
        if (addr_q == LAST_ADDR) state_d = S_DRAIN;
        else addr_d = addr_q + 6'd1;
      end
      S_DRAIN: begin
        board_d   = cap_board;
        heights_d = cap_cnt;
        full_d    = cap_full;
        valid_d   = 1'b1;
        state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      addr_q    <= 6'd0;
      addr_d1_q <= 6'd0;
      vld_d1_q  <= 1'b0;
      col_q     <= 3'd0;
      shadow_q  <= '0;
      cnt_q     <= '0;
      board_q   <= '0;
      heights_q <= '0;
      full_q    <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      addr_d1_q <= addr_q;
      vld_d1_q  <= (state_q == S_READ);
      col_q     <= col_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      board_q   <= board_d;
      heights_q <= heights_d;
      full_q    <= full_d;
      valid_q   <= valid_d;
    end
  end

  assign ram_addr    = addr_q;
  assign board       = board_q;
  assign heights     = heights_q;
  assign board_full  = full_q;
  assign busy        = (state_q == S_READ) || (state_q == S_DRAIN);
  assign done        = (state_q == S_DONE);
  assign board_valid = valid_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_board_reader.sv
// Bench for board_reader: behavioural board RAM, reference board/height model, and an
// expected-commit queue filled when a scan is started and drained when done fires.
module tb_board_reader;

  localparam int W = 98 + 21 + 1;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic [5:0]  ram_addr;
  logic [1:0]  ram_q;
  logic [97:0] board;
  logic [20:0] heights;
  logic        board_full, busy, done, board_valid;
  logic [1:0]  dbg_state;

  logic [1:0]   mem [0:48];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] e;
  logic [97:0]  eb, last_board;
  logic [20:0]  eh;
  logic         ef;
  int n_tests = 0;
  int n_fail  = 0;

  board_reader dut (
    .CLOCK_50(clk), .resetn(resetn), .start(start), .ram_addr(ram_addr), .ram_q(ram_q),
    .board(board), .heights(heights), .board_full(board_full), .busy(busy), .done(done),
    .board_valid(board_valid), .dbg_state(dbg_state)
  );

  // Clock / reset / RAM model
  always #5 clk = ~clk;
  always @(posedge clk) ram_q <= mem[ram_addr];

  function automatic logic [W-1:0] model();
    logic [97:0] b;
    logic [20:0] h;
    logic [2:0]  cnt;
    b = '0;
    h = '0;
    for (int a = 0; a < 49; a++) b[2*a +: 2] = mem[a];
    for (int c = 0; c < 7; c++) begin
      cnt = 3'd0;
      for (int r = 0; r < 7; r++) if (mem[c + 7*r] != 2'b00) cnt = cnt + 3'd1;
      h[3*c +: 3] = cnt;
    end
    return {b, h, (h == 21'h1FFFFF)};
  endfunction

  // Driver tasks
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(model());
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int from_cyc, input int max, output int cyc);
    cyc = from_cyc;
    do begin
      @(negedge clk);
      cyc++;
    end while (done !== 1'b1 && cyc < max);
    if (done !== 1'b1) cyc = -1;
  endtask

  task automatic pop_exp();
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty got done with no expectation");
      e = '0;
    end else e = exp_q.pop_front();
    {eb, eh, ef} = e;
  endtask

  // Tests
  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (ram_addr !== 6'd0) begin n_fail++; $display("FAIL reset_addr got %0d exp 0", ram_addr); end
    n_tests++; if (board !== 98'd0) begin n_fail++; $display("FAIL reset_board got %h exp 0", board); end
    n_tests++; if (heights !== 21'd0) begin n_fail++; $display("FAIL reset_heights got %h exp 0", heights); end
    n_tests++; if ({board_full, busy, done, board_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got %b exp 0000", {board_full, busy, done, board_valid}); end
    resetn = 1'b1;
  endtask

  task automatic test_all_zero();
    int cyc;
    for (int a = 0; a < 49; a++) mem[a] = 2'b00;
    pulse_start();
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy got %b exp 1", busy); end
    wait_done(0, 80, cyc);
    n_tests++; if (cyc != 50) begin n_fail++; $display("FAIL zero_latency got %0d exp 50", cyc); end
    pop_exp();
    n_tests++; if (board !== eb || heights !== eh || board_full !== ef) begin
      n_fail++; $display("FAIL zero_commit got %h/%h/%b exp %h/%h/%b", board, heights, board_full, eb, eh, ef); end
    n_tests++; if (board_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_valid got valid=%b busy=%b exp 1/0", board_valid, busy); end
    last_board = eb;
    @(negedge clk);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_pattern();
    int cyc;
    logic [7:0] byte_pat;
    byte_pat = 8'hE4;
    for (int a = 0; a < 49; a++) mem[a] = 2'(a);
    pulse_start();
    wait_done(0, 80, cyc);
    n_tests++; if (cyc != 50) begin n_fail++; $display("FAIL pattern_latency got %0d exp 50", cyc); end
    pop_exp();
    n_tests++; if (board !== eb) begin n_fail++; $display("FAIL pattern_board got %h exp %h", board, eb); end
    n_tests++; if (board[7:0] !== byte_pat || board[97:96] !== 2'b00) begin
      n_fail++; $display("FAIL pattern_bytes got %h/%b exp e4/00", board[7:0], board[97:96]); end
    n_tests++; if (heights[2:0] !== 3'd5 || heights[5:3] !== 3'd5 || heights[11:9] !== 3'd6) begin
      n_fail++; $display("FAIL pattern_cols got %0d %0d %0d exp 5 5 6", heights[2:0], heights[5:3], heights[11:9]); end
    n_tests++; if (heights !== eh || board_full !== ef) begin
      n_fail++; $display("FAIL pattern_heights got %h/%b exp %h/%b", heights, board_full, eh, ef); end
    last_board = eb;
  endtask

  task automatic test_full_addr();
    int cyc, bad;
    for (int a = 0; a < 49; a++) mem[a] = 2'b01;
    pulse_start();
    bad = 0;
    if (ram_addr !== 6'd0) bad++;
    for (int k = 1; k <= 48; k++) begin
      @(negedge clk);
      if (ram_addr !== 6'(k)) bad++;
    end
    @(negedge clk);
    if (ram_addr !== 6'd48 || busy !== 1'b1) bad++;
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL addr_sequence got %0d bad cycles exp 0", bad); end
    wait_done(49, 80, cyc);
    n_tests++; if (cyc != 50) begin n_fail++; $display("FAIL full_latency got %0d exp 50", cyc); end
    pop_exp();
    n_tests++; if (heights !== 21'h1FFFFF || heights !== eh) begin
      n_fail++; $display("FAIL full_heights got %h exp %h", heights, eh); end
    n_tests++; if (board_full !== 1'b1 || board !== eb) begin
      n_fail++; $display("FAIL full_flag got %b/%h exp 1/%h", board_full, board, eb); end
    last_board = eb;
  endtask

  task automatic test_restart_ignored();
    int cyc, held_bad, extra;
    for (int a = 0; a < 49; a++) mem[a] = 2'($urandom_range(0, 3));
    pulse_start();
    cyc = 0;
    held_bad = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 19) start = 1'b1;
      if (cyc == 20) start = 1'b0;
      if ((cyc == 20 || cyc == 40 || cyc == 49) && board !== last_board) held_bad++;
    end while (done !== 1'b1 && cyc < 80);
    n_tests++; if (cyc != 50) begin n_fail++; $display("FAIL restart_latency got %0d exp 50", cyc); end
    n_tests++; if (held_bad != 0) begin n_fail++; $display("FAIL restart_held got %0d changes exp 0", held_bad); end
    pop_exp();
    n_tests++; if (board !== eb || heights !== eh || board_full !== ef) begin
      n_fail++; $display("FAIL restart_commit got %h/%h exp %h/%h", board, heights, eb, eh); end
    last_board = eb;
    extra = 0;
    repeat (60) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_tests++; if (extra != 0) begin n_fail++; $display("FAIL restart_extra_scan got %0d cycles exp 0", extra); end
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    for (int a = 0; a < 49; a++) mem[a] = 2'($urandom_range(1, 3));
    pulse_start();
    repeat (30) @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    n_tests++; if (board !== 98'd0 || heights !== 21'd0 || ram_addr !== 6'd0) begin
      n_fail++; $display("FAIL midreset_data got %h/%h/%0d exp 0/0/0", board, heights, ram_addr); end
    n_tests++; if ({board_full, busy, done, board_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL midreset_flags got %b exp 0000", {board_full, busy, done, board_valid}); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    pulse_start();
    n_tests++; if (ram_addr !== 6'd0) begin n_fail++; $display("FAIL midreset_addr0 got %0d exp 0", ram_addr); end
    @(negedge clk);
    n_tests++; if (ram_addr !== 6'd1) begin n_fail++; $display("FAIL midreset_addr1 got %0d exp 1", ram_addr); end
    wait_done(1, 80, cyc);
    n_tests++; if (cyc != 50) begin n_fail++; $display("FAIL midreset_latency got %0d exp 50", cyc); end
    pop_exp();
    n_tests++; if (board !== eb || heights !== eh || board_full !== ef || board_valid !== 1'b1) begin
      n_fail++; $display("FAIL midreset_commit got %h/%h/%b exp %h/%h/%b", board, heights, board_full, eb, eh, ef); end
    last_board = eb;
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int a = 0; a < 49; a++) mem[a] = 2'($urandom_range(0, 3));
    @(negedge clk);
    start = 1'b1;
    exp_q.push_back(model());
    cyc = -1;
    for (int s = 0; s < 3; s++) begin
      wait_done((s == 0) ? -1 : 0, 100, cyc);
      n_tests++; if (cyc != ((s == 0) ? 50 : 51)) begin
        n_fail++; $display("FAIL b2b_interval scan %0d got %0d exp %0d", s, cyc, (s == 0) ? 50 : 51); end
      pop_exp();
      n_tests++; if (board !== eb || heights !== eh || board_full !== ef) begin
        n_fail++; $display("FAIL b2b_commit scan %0d got %h/%h exp %h/%h", s, board, heights, eb, eh); end
      if (s < 2) begin
        for (int a = 0; a < 49; a++) mem[a] = 2'($urandom_range(0, 3));
        exp_q.push_back(model());
      end else start = 1'b0;
    end
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_idle got busy=%b pending=%0d exp 0/0", busy, exp_q.size()); end
  endtask

  initial begin
    for (int a = 0; a < 49; a++) mem[a] = 2'b00;
    last_board = '0;
    test_reset();
    test_all_zero();
    test_pattern();
    test_full_addr();
    test_restart_ignored();
    test_reset_mid_scan();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
